// File: rtl/cacheline_adaptor_if.sv
// Cache-line / memory-burst bundle for the cacheline adaptor.
// The environment (cache plus memory) uses master; the adaptor uses slave.
interface cacheline_adaptor_if;
  localparam int unsigned addr_w  = 32;
  localparam int unsigned s_line  = 256;
  localparam int unsigned s_burst = 64;

  // Cache side
  logic [addr_w-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic               resp_o;

  // Memory side
  logic [addr_w-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [s_burst-1:0] burst_o;
  logic [s_burst-1:0] burst_i;
  logic               resp_i;

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, four-beat memory burst port.
// Fills are staged and committed to line_o on the last beat; writebacks use a separate buffer.
module cacheline_adaptor (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);
  localparam int unsigned addr_w   = 32;
  localparam int unsigned s_offset = 5;
  localparam int unsigned s_line   = 256;
  localparam int unsigned s_burst  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [s_line-1:0] rbuf;
  logic [s_line-1:0] wbuf;

  assign cnt_nxt = cnt + 2'd1;

  // Single-process FSM; every bus output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      rbuf          <= '0;
      wbuf          <= '0;
      bus.line_o    <= '0;
      bus.resp_o    <= 1'b0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.burst_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_o <= 1'b0;
          if (bus.write_i) begin
            wbuf          <= bus.line_i;
            bus.burst_o   <= bus.line_i[s_burst-1:0];
            bus.address_o <= {bus.address_i[addr_w-1:s_offset], {s_offset{1'b0}}};
            cnt           <= 2'd0;
            bus.write_o   <= 1'b1;
            state         <= WR;
          end else if (bus.read_i) begin
            bus.address_o <= {bus.address_i[addr_w-1:s_offset], {s_offset{1'b0}}};
            cnt           <= 2'd0;
            bus.read_o    <= 1'b1;
            state         <= RD;
          end
        end

        RD: begin
          if (bus.resp_i) begin
            rbuf[s_burst*32'(cnt) +: s_burst] <= bus.burst_i;
            cnt <= cnt_nxt;
            if (cnt == 2'd3) begin
              // Beats 0..2 are already staged; the final beat goes straight to the top lane.
              bus.line_o <= {bus.burst_i, rbuf[3*s_burst-1:0]};
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
              state      <= DONE;
            end
          end
        end

        WR: begin
          if (bus.resp_i) begin
            cnt <= cnt_nxt;
            if (cnt == 2'd3) begin
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
              state       <= DONE;
            end else begin
              bus.burst_o <= wbuf[s_burst*32'(cnt_nxt) +: s_burst];
            end
          end
        end

        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor against a transaction-level model.
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b0;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [255:0] exp_line = '0;   // what line_o must hold outside a completed fill
  logic [31:0]  exp_addr = '0;
  logic [255:0] cur_wline = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic start_req(input logic w, input logic r, input logic [31:0] a, input logic [255:0] l);
    bus.address_i = a;
    bus.write_i   = w;
    bus.read_i    = r;
    bus.line_i    = l;
    exp_addr      = {a[31:5], 5'b0};
    if (w) cur_wline = l;
  endtask

  // Check all outputs that must be quiet while the adaptor sits idle.
  task automatic check_quiet(input string tag);
    check({tag, "_read_o"},  bus.read_o,  1'b0);
    check({tag, "_write_o"}, bus.write_o, 1'b0);
    check({tag, "_resp_o"},  bus.resp_o,  1'b0);
    check({tag, "_line_o"},  bus.line_o,  exp_line);
  endtask

  // Called at the negedge of cycle 0 (request on the inputs); returns at the negedge of cycle k+2.
  task automatic run_burst(input bit is_wr, input bit keep_rd, input bit directed,
                           input logic [15:0] pat, input int pat_len);
    logic [255:0] fill;
    logic [63:0]  data;
    int nb;
    int cyc;
    bit r;
    fill = '0;
    nb   = 0;
    cyc  = 0;
    @(negedge clk);
    bus.write_i = 1'b0;
    if (!keep_rd) bus.read_i = 1'b0;
    while (nb < 4) begin
      check(is_wr ? "write_o_busy" : "read_o_busy", is_wr ? bus.write_o : bus.read_o, 1'b1);
      check(is_wr ? "read_o_in_wr" : "write_o_in_rd", is_wr ? bus.read_o : bus.write_o, 1'b0);
      check("resp_o_busy", bus.resp_o, 1'b0);
      check("address_o", bus.address_o, exp_addr);
      if (is_wr) check("burst_o_lane", bus.burst_o, cur_wline[64*nb +: 64]);
      else       check("line_o_hold", bus.line_o, exp_line);
      if (pat_len > 0 && cyc < pat_len) r = pat[cyc];
      else if (directed || cyc >= 40)   r = 1'b1;
      else                              r = ($urandom_range(0, 2) != 0);
      data = directed ? {16{4'(nb)}} : {$urandom, $urandom};
      bus.resp_i  = r;
      bus.burst_i = data;
      if (r) begin
        fill[64*nb +: 64] = data;
        nb++;
      end
      cyc++;
      @(negedge clk);
    end
    // Cycle k+1: DONE. Noise on the memory side must be ignored.
    if (!is_wr) exp_line = fill;
    check("resp_o_done", bus.resp_o, 1'b1);
    check("read_o_done", bus.read_o, 1'b0);
    check("write_o_done", bus.write_o, 1'b0);
    check("line_o_done", bus.line_o, exp_line);
    bus.resp_i  = 1'($urandom_range(0, 1));
    bus.burst_i = {$urandom, $urandom};
    @(negedge clk);
    // Cycle k+2: back in IDLE.
    bus.resp_i = 1'b0;
    check("resp_o_pulse_end", bus.resp_o, 1'b0);
    check("read_o_idle", bus.read_o, 1'b0);
    check("write_o_idle", bus.write_o, 1'b0);
    check("line_o_idle", bus.line_o, exp_line);
  endtask

  // Idle cycles with memory-side noise: nothing may start or change.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = 1'($urandom_range(0, 1));
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
      check_quiet("idle");
    end
    bus.resp_i = 1'b0;
  endtask

  initial begin
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_address_o", bus.address_o, 32'h0);
    check("reset_burst_o", bus.burst_o, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed fill: beats in cycles 1-4, resp_o in cycle 5.
    start_req(1'b0, 1'b1, 32'h1234_567F, '0);
    run_burst(1'b0, 1'b0, 1'b1, 16'h0, 0);
    check("fill_addr", exp_addr, 32'h1234_5660);
    check("fill_line", bus.line_o, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});

    // Directed writeback with stalls between beats.
    start_req(1'b1, 1'b0, 32'hCAFE_0013,
              {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}});
    run_burst(1'b1, 1'b0, 1'b0, 16'h0069, 7);

    // Stalled fill: resp_i pattern 1,0,0,1,0,1,1.
    start_req(1'b0, 1'b1, 32'h0000_1FE4, '0);
    run_burst(1'b0, 1'b0, 1'b0, 16'h0069, 7);

    // Priority, request dropped: read must not start afterwards.
    start_req(1'b1, 1'b1, 32'h8000_0040, rand_line());
    run_burst(1'b1, 1'b0, 1'b0, 16'h0, 0);
    idle_noise(4);

    // Priority, read still held: read runs after the writeback returns to IDLE.
    start_req(1'b1, 1'b1, 32'h4444_4444, rand_line());
    run_burst(1'b1, 1'b1, 1'b0, 16'h0, 0);
    run_burst(1'b0, 1'b0, 1'b0, 16'h0, 0);

    // Reset after two fill beats.
    start_req(1'b0, 1'b1, 32'h0BAD_F00D, '0);
    @(negedge clk);
    bus.read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_line = '0;
    check_quiet("midrst");
    check("midrst_address_o", bus.address_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_req(1'b0, 1'b1, $urandom, '0);
    run_burst(1'b0, 1'b0, 1'b0, 16'h0, 0);

    // Back-to-back fills with read_i held across resp_o.
    start_req(1'b0, 1'b1, $urandom, '0);
    run_burst(1'b0, 1'b1, 1'b0, 16'h0, 0);
    run_burst(1'b0, 1'b0, 1'b0, 16'h0, 0);

    // Random mix of transactions.
    for (int t = 0; t < 24; t++) begin
      bit w;
      bit r;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      start_req(w, r, $urandom, rand_line());
      run_burst(w, 1'b0, 1'b0, 16'h0, 0);
      idle_noise($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
